// File: rtl/int_fp_mac_pkg.sv
// Shared definitions for the INT16/FP16 add datapath and its request arbiter.
package int_fp_mac_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    MODE_INT = 1'b0,
    MODE_FP  = 1'b1
  } mode_e;

  localparam logic [DATA_W-1:0] FP_QNAN    = 16'h7E00;
  localparam logic [4:0]        FP_EXP_MAX = 5'h1F;

endpackage

// File: rtl/int_fp_add.sv
// Combinational 16-bit adder: wrapping two's-complement INT16 add or IEEE FP16 add
// (round-to-nearest-even, gradual underflow, canonical quiet NaN).
module int_fp_add
  import int_fp_mac_pkg::*;
(
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd14;
    for (int k = 0; k < 14; k++) begin
      if (v[k]) n = 4'(13 - k);
    end
    return n;
  endfunction

  // n holds hidden bit at [13], fraction [12:3], guard/round/sticky [2:0].
  function automatic logic [15:0] fp_round_pack(input logic sign, input logic [5:0] ex,
                                                 input logic [13:0] n);
    logic [4:0]  e_field;
    logic        rup;
    logic [14:0] mag;
    if (ex >= 6'd31) return {sign, FP_EXP_MAX, 10'd0};
    e_field = n[13] ? ex[4:0] : 5'd0;
    rup     = n[2] & (n[3] | n[1] | n[0]);
    mag     = {e_field, n[12:3]} + {14'd0, rup};
    return {sign, mag};
  endfunction

  logic signed [DATA_W-1:0] w_int_sum;
  logic [15:0] w_big, w_sml, w_fp_sum;
  logic [10:0] w_sig_l, w_sig_s;
  logic [4:0]  w_ee_l, w_ee_s, w_d;
  logic [13:0] w_m_l, w_m_s0, w_m_s, w_norm;
  logic [14:0] w_sum;
  logic [5:0]  w_ex, w_lz, w_sh, w_sh_max;
  logic        w_sub, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_int_sum = $signed(i_a) + $signed(i_b);

  always_comb begin
    w_big   = (i_a[14:0] >= i_b[14:0]) ? i_a : i_b;
    w_sml   = (i_a[14:0] >= i_b[14:0]) ? i_b : i_a;
    w_sig_l = {|w_big[14:10], w_big[9:0]};
    w_sig_s = {|w_sml[14:10], w_sml[9:0]};
    w_ee_l  = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
    w_ee_s  = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
    w_d     = w_ee_l - w_ee_s;
    w_m_l   = {w_sig_l, 3'b000};
    w_m_s0  = {w_sig_s, 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky LSB.
    if (w_d >= 5'd14)
      w_m_s = {13'd0, |w_sig_s};
    else
      w_m_s = (w_m_s0 >> w_d) | {13'd0, |(w_m_s0 & ((14'd1 << w_d) - 14'd1))};
    w_sub = w_big[15] ^ w_sml[15];
    w_sum = w_sub ? ({1'b0, w_m_l} - {1'b0, w_m_s}) : ({1'b0, w_m_l} + {1'b0, w_m_s});
    w_lz     = {2'b00, lzc14(w_sum[13:0])};
    w_sh_max = {1'b0, w_ee_l} - 6'd1;
    if (w_sum[14]) begin
      w_sh   = 6'd0;
      w_norm = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_ex   = {1'b0, w_ee_l} + 6'd1;
    end else begin
      w_sh   = (w_lz < w_sh_max) ? w_lz : w_sh_max;
      w_norm = w_sum[13:0] << w_sh;
      w_ex   = {1'b0, w_ee_l} - w_sh;
    end
    w_a_nan = (i_a[14:10] == FP_EXP_MAX) && (i_a[9:0] != 10'd0);
    w_b_nan = (i_b[14:10] == FP_EXP_MAX) && (i_b[9:0] != 10'd0);
    w_a_inf = (i_a[14:10] == FP_EXP_MAX) && (i_a[9:0] == 10'd0);
    w_b_inf = (i_b[14:10] == FP_EXP_MAX) && (i_b[9:0] == 10'd0);
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15])))
      w_fp_sum = FP_QNAN;
    else if (w_a_inf)
      w_fp_sum = i_a;
    else if (w_b_inf)
      w_fp_sum = i_b;
    else if (w_sum == 15'd0)
      w_fp_sum = {~w_sub & w_big[15], 15'd0};
    else
      w_fp_sum = fp_round_pack(w_big[15], w_ex, w_norm);
  end

  assign o_sum = (i_mode == MODE_FP) ? w_fp_sum : w_int_sum;

endmodule

// File: rtl/int_fp_add_rr_arb.sv
// Single-grant arbiter: round-robin from a pointer when INT_FP_ADD_ARB_RR_EN is
// defined, otherwise fixed priority with the lowest eligible index winning.
module int_fp_add_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
`ifdef INT_FP_ADD_ARB_RR_EN
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_ptr_nxt,
`endif
  input  logic [NUM_REQ-1:0] i_elig,
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef INT_FP_ADD_ARB_RR_EN
  function automatic int search_idx(input logic [PTR_W-1:0] ptr, input int k);
    return (int'(ptr) + k) % NUM_REQ;
  endfunction

  // Walk the search order backwards so the earliest eligible slot is written last.
  always_comb begin
    o_grant   = '0;
    o_ptr_nxt = i_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_elig[search_idx(i_ptr, k)]) begin
        o_grant                        = '0;
        o_grant[search_idx(i_ptr, k)]  = 1'b1;
        o_ptr_nxt = PTR_W'((search_idx(i_ptr, k) + 1) % NUM_REQ);
      end
    end
  end
`else
  always_comb begin
    o_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_elig[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/int_fp_add_arb.sv
// NUM_REQ requesters share one int_fp_add; each has a one-deep registered result slot.
// Define INT_FP_ADD_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module int_fp_add_arb
  import int_fp_mac_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W*NUM_REQ-1:0] rsp_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        w_elig, w_grant;
  logic                      w_mode;
  logic [DATA_W-1:0]         w_op_a, w_op_b, w_sum;
  logic [NUM_REQ-1:0]        r_vld_p1;
  logic [DATA_W*NUM_REQ-1:0] r_data_p1;

  // A slot can take a new result if it is empty or being drained this cycle.
  assign w_elig = {NUM_REQ{~rst}} & req_valid & (~r_vld_p1 | rsp_ready);

`ifdef INT_FP_ADD_ARB_RR_EN
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;

  int_fp_add_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_ptr     (r_ptr),
    .o_ptr_nxt (w_ptr_nxt),
    .i_elig    (w_elig),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end
`else
  int_fp_add_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );
`endif

  always_comb begin
    w_mode = MODE_INT;
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_mode = req_mode[i];
        w_op_a = req_a[DATA_W*i +: DATA_W];
        w_op_b = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  int_fp_add u_add (
    .i_mode (w_mode),
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .o_sum  (w_sum)
  );

  // p0 -> p1: adder result captured into the granted requester's slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= '0;
      r_data_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          r_vld_p1[i]                    <= 1'b1;
          r_data_p1[DATA_W*i +: DATA_W] <= w_sum;
        end else if (rsp_ready[i]) begin
          r_vld_p1[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_vld_p1;
  assign rsp_data  = r_data_p1;
  assign busy      = |r_vld_p1;

endmodule

// File: tb/tb_int_fp_add_arb.sv
// Self-checking bench for int_fp_add_arb (NUM_REQ=2): directed scenarios plus a
// randomized run against a real-arithmetic FP16/INT16 reference model.
module tb_int_fp_add_arb;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0, req_ready, req_mode = '0;
  logic [16*N-1:0]  req_a = '0, req_b = '0;
  logic [N-1:0]     rsp_valid, rsp_ready = '0;
  logic [16*N-1:0]  rsp_data;
  logic             busy;

  int errs = 0;
  int checks = 0;

  logic [N-1:0] m_vld;
  logic [15:0]  m_data [N];
  int           m_ptr;

  int_fp_add_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
    else        for (int k = 0; k < -e; k++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = m * pow2(-24);
    else        v = (m + 1024) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic int rne(input real q);
    int  fl = $rtoi(q);
    real fr = q - fl;
    if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
    return fl;
  endfunction

  function automatic logic [15:0] r2fp(input real s, input logic zero_sign);
    logic sign;
    real  mag;
    int   e, n;
    if (s == 0.0) return {zero_sign, 15'd0};
    sign = (s < 0.0);
    mag  = sign ? -s : s;
    if (mag < pow2(-14)) begin
      n = rne(mag * pow2(24));
      return {sign, 15'(n)};
    end
    e = -14;
    while (e < 16 && mag >= pow2(e + 1)) e++;
    n = rne(mag * pow2(10 - e));
    if (n == 2048) begin n = 1024; e++; end
    if (e > 15) return {sign, 15'h7C00};
    return {sign, 5'(e + 15), 10'(n - 1024)};
  endfunction

  function automatic logic [15:0] ref_op(input logic mode, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    if (mode) return r2fp(fp2r(a) + fp2r(b), a[15] & b[15]);
    s = {1'b0, a} + {1'b0, b};
    return s[15:0];
  endfunction

  function automatic logic [N-1:0] exp_grant();
    int start, idx;
    logic [N-1:0] g;
`ifdef INT_FP_ADD_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req_valid[idx] && (!m_vld[idx] || rsp_ready[idx])) begin
        g = '0;
        g[idx] = 1'b1;
        return g;
      end
    end
    return '0;
  endfunction

  task automatic model_commit(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_vld[i]  = 1'b1;
        m_data[i] = ref_op(req_mode[i], req_a[16*i +: 16], req_b[16*i +: 16]);
        m_ptr     = (i + 1) % N;
      end else if (rsp_ready[i]) begin
        m_vld[i] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_data[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_mode = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_op(input logic fp);
    logic [15:0] v = 16'($urandom);
    if ($urandom_range(0, 3) == 0) v[14:12] = 3'b000;
    if (fp && v[14:10] == 5'h1F) v[14] = 1'b0;
    return v;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; rsp_ready = '1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk);
    end
    rst = 1'b0; req_valid = '0; rsp_ready = '0;
    model_reset();
  endtask

  task automatic test_single_int();
    do_reset();
    req_valid = 2'b01; req_mode = 2'b00; req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0004;
    #1;
    checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL int_ready: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL int_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_data[15:0] !== 16'h0007) begin errs++; $display("FAIL int_rsp_data: got %h want 0007", rsp_data[15:0]); end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL int_busy: got %b want 1", busy); end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL int_drain: got %b want 00", rsp_valid); end
    checks++; if (rsp_data[15:0] !== 16'h0007) begin errs++; $display("FAIL int_hold: got %h want 0007", rsp_data[15:0]); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL int_busy_clr: got %b want 0", busy); end
  endtask

  task automatic test_single_fp();
    do_reset();
    req_valid = 2'b10; req_mode = 2'b10; req_a[31:16] = 16'h3C00; req_b[31:16] = 16'h3C00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL fp_ready: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 2'b10) begin errs++; $display("FAIL fp_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_data[31:16] !== 16'h4000) begin errs++; $display("FAIL fp_rsp_data: got %h want 4000", rsp_data[31:16]); end
  endtask

  task automatic test_contention();
    logic [N-1:0] want, prev;
    logic [15:0]  prev_sum;
    int           gi;
    do_reset();
    rsp_ready = '1; req_valid = '1; req_mode = '0;
    prev = '0; prev_sum = '0;
    for (int c = 0; c < 8; c++) begin
      req_a = {16'($urandom), 16'($urandom)};
      req_b = {16'($urandom), 16'($urandom)};
`ifdef INT_FP_ADD_ARB_RR_EN
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      #1;
      if (c > 0) begin
        gi = prev[1] ? 1 : 0;
        checks++; if (rsp_valid !== prev) begin errs++; $display("FAIL cont_rsp_valid c=%0d: got %b want %b", c, rsp_valid, prev); end
        checks++; if (rsp_data[16*gi +: 16] !== prev_sum) begin errs++; $display("FAIL cont_rsp_data c=%0d: got %h want %h", c, rsp_data[16*gi +: 16], prev_sum); end
      end
      checks++; if (req_ready !== want) begin errs++; $display("FAIL cont_grant c=%0d: got %b want %b", c, req_ready, want); end
      gi = want[1] ? 1 : 0;
      prev = want;
      prev_sum = req_a[16*gi +: 16] + req_b[16*gi +: 16];
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [15:0] want1;
    do_reset();
    req_valid = 2'b01; req_mode = 2'b00; req_a[15:0] = 16'h1234; req_b[15:0] = 16'h0101;
    @(negedge clk);
    rsp_ready = 2'b10; req_valid = 2'b11; req_a[15:0] = 16'h0FFF; req_b[15:0] = 16'h0001;
    for (int c = 0; c < 4; c++) begin
      req_a[31:16] = 16'($urandom); req_b[31:16] = 16'($urandom);
      want1 = req_a[31:16] + req_b[31:16];
      #1;
      checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_grant c=%0d: got %b want 10", c, req_ready); end
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 2'b11) begin errs++; $display("FAIL bp_rsp_valid c=%0d: got %b want 11", c, rsp_valid); end
      checks++; if (rsp_data[15:0] !== 16'h1335) begin errs++; $display("FAIL bp_slot0_hold c=%0d: got %h want 1335", c, rsp_data[15:0]); end
      checks++; if (rsp_data[31:16] !== want1) begin errs++; $display("FAIL bp_slot1 c=%0d: got %h want %h", c, rsp_data[31:16], want1); end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_valid = 2'b01; req_mode = 2'b00; req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_data[15:0] !== 16'h000B) begin errs++; $display("FAIL mid_pre_data: got %h want 000b", rsp_data[15:0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL mid_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL mid_rsp_data: got %h want 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0; model_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL mid_first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      req_mode  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[16*i +: 16] = rand_op(req_mode[i]);
        if ($urandom_range(0, 3) == 0)
          req_b[16*i +: 16] = {~req_a[16*i + 15], req_a[16*i + 2 +: 13], 2'($urandom)};
        else
          req_b[16*i +: 16] = rand_op(req_mode[i]);
      end
      #1;
      g = exp_grant();
      checks++; if (req_ready !== g) begin errs++; $display("FAIL rand_grant c=%0d: got %b want %b", c, req_ready, g); end
      model_commit(g);
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== m_vld) begin errs++; $display("FAIL rand_rsp_valid c=%0d: got %b want %b", c, rsp_valid, m_vld); end
      checks++; if (busy !== (|m_vld)) begin errs++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, |m_vld); end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rsp_data[16*i +: 16] !== m_data[i]) begin
          errs++;
          $display("FAIL rand_data c=%0d slot=%0d mode=%b: got %h want %h", c, i, req_mode[i], rsp_data[16*i +: 16], m_data[i]);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_int();
    test_single_fp();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
